mem_bist_ctrl: RTL and testbench

- Hardware built-in self-test sequencer for the 32x8 synchronous memory.
- Sits directly upstream of the memory and drives its read/write/addr/data_in pins. Consumes data_out and checks it.
- Runs two phases autonomously: clear test (write 0 everywhere, read back and check for 0), then data=address test (write each address's own value, read back and check).
- Reports pass/fail, a saturating error count and the first failing address.

---
 rtl/mem_bist_pkg.sv | 26 ++
 rtl/mem_bist_checker.sv | 49 ++++
 rtl/mem_bist_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the 32x8 memory BIST sequencer.
// Holds the FSM/phase encodings and the per-phase expected-data rule.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CHK,
        DONE
    } state_e;

    typedef enum logic {
        PH_CLEAR,
        PH_ADDR
    } phase_e;

    localparam int ERR_MAX = 255;
    localparam int ERR_W   = 8;

    // Clear phase expects zero; data=address phase expects the zero-extended address.
    function automatic logic [31:0] expected_data(input phase_e ph, input logic [31:0] addr);
        return (ph == PH_ADDR) ? addr : 32'd0;
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data checker: flags mismatches, keeps a saturating error count
// and latches the address of the first failure since the last clear.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_expected,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_mismatch,
    output logic [ERR_W-1:0]      o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_fail_addr
);

    logic [ERR_W-1:0]      r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_fail_addr;
    logic                  w_mismatch;

    // Case-inequality so an unknown bit on the read bus is treated as a failure.
    assign w_mismatch = i_en && (i_data !== i_expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count       <= '0;
            r_first_fail_addr <= '0;
        end else if (i_clear) begin
            r_err_count       <= '0;
            r_first_fail_addr <= '0;
        end else if (w_mismatch) begin
            if (r_err_count == '0) begin
                r_first_fail_addr <= i_addr;
            end
            if (r_err_count != ERR_W'(ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign o_mismatch        = w_mismatch;
    assign o_err_count       = r_err_count;
    assign o_first_fail_addr = r_first_fail_addr;

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer: clear test then data=address test over every location,
// driving the memory pins from registers and reporting pass/fail.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  phase,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out
);

    state_e                r_state;
    phase_e                r_phase;
    logic                  r_read;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;

    logic                  w_clear;
    logic                  w_chk_en;
    logic                  w_last;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] w_expected;
    logic [7:0]            w_err_count;
    logic [ADDR_WIDTH-1:0] w_first_fail_addr;

    assign w_clear    = (r_state == IDLE) && start;
    assign w_chk_en   = (r_state == CHK);
    assign w_last     = (r_addr == ADDR_WIDTH'(DEPTH - 1));
    assign w_expected = DATA_WIDTH'(expected_data(r_phase, 32'(r_addr)));

    mem_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checker (
        .clk               (clk),
        .rst               (rst),
        .i_clear           (w_clear),
        .i_en              (w_chk_en),
        .i_data            (data_out),
        .i_expected        (w_expected),
        .i_addr            (r_addr),
        .o_mismatch        (w_mismatch),
        .o_err_count       (w_err_count),
        .o_first_fail_addr (w_first_fail_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_phase   <= PH_CLEAR;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_data_in <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= WR;
                        r_phase   <= PH_CLEAR;
                        r_addr    <= '0;
                        r_write   <= 1'b1;
                        r_read    <= 1'b0;
                        r_data_in <= DATA_WIDTH'(expected_data(PH_CLEAR, 32'd0));
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                WR: begin
                    if (w_last) begin
                        r_state   <= RD;
                        r_write   <= 1'b0;
                        r_read    <= 1'b1;
                        r_addr    <= '0;
                        r_data_in <= '0;
                    end else begin
                        r_addr    <= r_addr + ADDR_WIDTH'(1);
                        r_data_in <= DATA_WIDTH'(expected_data(r_phase, 32'(r_addr) + 32'd1));
                    end
                end
                RD: begin
                    r_read  <= 1'b0;
                    r_state <= CHK;
                end
                CHK: begin
                    if (!w_last) begin
                        r_addr  <= r_addr + ADDR_WIDTH'(1);
                        r_read  <= 1'b1;
                        r_state <= RD;
                    end else if (r_phase == PH_CLEAR) begin
                        r_phase   <= PH_ADDR;
                        r_state   <= WR;
                        r_write   <= 1'b1;
                        r_addr    <= '0;
                        r_data_in <= DATA_WIDTH'(expected_data(PH_ADDR, 32'd0));
                    end else begin
                        // The final compare lands in the checker on this same edge,
                        // so fold it in to have pass valid together with done.
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_count == 8'd0) && !w_mismatch;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_addr  <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = w_err_count;
    assign first_fail_addr = w_first_fail_addr;
    assign phase           = (r_phase == PH_ADDR);
    assign read            = r_read;
    assign write           = r_write;
    assign addr            = r_addr;
    assign data_in         = r_data_in;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: fault-injecting memory model, memory-op and result
// scoreboards fed by the driver and drained by negedge monitors.
module tb_mem_bist_ctrl;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int N   = 32;
    localparam int AW2 = 9;
    localparam int DW2 = 9;
    localparam int N2  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;

    logic          busy, done, pass, phase, read, write;
    logic [7:0]    err_count;
    logic [AW-1:0] ffa, addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    logic           busy2, done2, pass2, phase2, read2, write2;
    logic [7:0]     err_count2;
    logic [AW2-1:0] ffa2, addr2;
    logic [DW2-1:0] data_in2;
    logic [DW2-1:0] data_out2;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_addr(ffa), .phase(phase), .read(read),
        .write(write), .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    mem_bist_ctrl #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW2), .DEPTH(N2)) u_dut_big (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_fail_addr(ffa2), .phase(phase2), .read(read2),
        .write(write2), .addr(addr2), .data_in(data_in2), .data_out(data_out2)
    );

    int total = 0;
    int bad   = 0;
    int pcyc  = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    // Fault configuration of the memory model.
    logic [7:0] or_mask;
    logic [7:0] and_mask;
    bit         ff_mode;
    bit         prot_en;
    int         prot_addr;

    logic [DW-1:0]  mem  [N];
    logic [DW2-1:0] mem2 [N2];

    always @(posedge clk) begin
        if (write && !(prot_en && phase && int'(addr) == prot_addr)) mem[addr] <= data_in;
        if (read) begin
            if (ff_mode) data_out <= 8'hFF;
            else         data_out <= (mem[addr] | or_mask) & ~and_mask;
        end
    end

    // Wide instance: every data bit stuck-at-1.
    always @(posedge clk) begin
        if (write2) mem2[addr2] <= data_in2;
        if (read2)  data_out2 <= mem2[addr2] | {DW2{1'b1}};
    end

    typedef struct {
        bit is_wr;
        int a;
        int d;
        bit ph;
    } op_t;

    typedef struct {
        int cyc;
        bit pass;
        int err;
        int ffa;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what each location reads back in each phase, given the faults.
    function automatic res_t model(input int cyc);
        res_t r;
        int   e;
        int   first;
        int   stored;
        int   rd;
        int   exp_v;
        e = 0;
        first = -1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < N; a++) begin
                stored = (ph == 1 && !(prot_en && a == prot_addr)) ? a : 0;
                rd     = ff_mode ? 255 : ((stored | int'(or_mask)) & ~int'(and_mask) & 255);
                exp_v  = (ph == 1) ? a : 0;
                if (rd != exp_v) begin
                    e++;
                    if (first < 0) first = a;
                end
            end
        end
        r.cyc  = cyc;
        r.pass = (e == 0);
        r.err  = (e > 255) ? 255 : e;
        r.ffa  = (first < 0) ? 0 : first;
        return r;
    endfunction

    task automatic push_ops();
        op_t o;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < N; a++) begin
                o.is_wr = 1'b1; o.a = a; o.d = (ph == 1) ? a : 0; o.ph = (ph == 1);
                op_q.push_back(o);
            end
            for (int a = 0; a < N; a++) begin
                o.is_wr = 1'b0; o.a = a; o.d = 0; o.ph = (ph == 1);
                op_q.push_back(o);
            end
        end
    endtask

    // Memory-op monitor.
    always @(negedge clk) begin
        op_t e;
        if (!rst && (read || write)) begin
            check("rw_exclusive", int'(read & write), 0);
            check("op_expected", int'(op_q.size() > 0), 1);
            if (op_q.size() > 0) begin
                e = op_q.pop_front();
                check("op_kind", int'(write), int'(e.is_wr));
                check("op_addr", int'(addr), e.a);
                if (e.is_wr) check("op_data", int'(data_in), e.d);
                check("op_phase", int'(phase), int'(e.ph));
                check("op_busy", int'(busy), 1);
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        res_t e;
        if (!rst && done) begin
            check("done_expected", int'(res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
                e = res_q.pop_front();
                check("done_cycle", pcyc, e.cyc);
                check("pass", int'(pass), int'(e.pass));
                check("err_count", int'(err_count), e.err);
                check("first_fail_addr", int'(ffa), e.ffa);
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic clear_faults();
        or_mask = 8'h00; and_mask = 8'h00; ff_mode = 1'b0; prot_en = 1'b0; prot_addr = 0;
    endtask

    task automatic random_faults();
        int m;
        clear_faults();
        m = $urandom_range(0, 4);
        case (m)
            1: or_mask   = 8'(1 << $urandom_range(0, 7));
            2: and_mask  = 8'(1 << $urandom_range(0, 7));
            3: begin prot_en = 1'b1; prot_addr = $urandom_range(0, N - 1); end
            4: begin or_mask = 8'($urandom_range(0, 255)); and_mask = 8'($urandom_range(0, 255)) & ~or_mask; end
            default: ;
        endcase
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("done_within_bound", int'(done), 1);
    endtask

    task automatic run_one(input bit poke);
        @(negedge clk);
        start = 1'b1;
        res_q.push_back(model(pcyc + 193));
        push_ops();
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (48) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(400);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_read"}, int'(read), 0);
        check({tag, "_write"}, int'(write), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_ffa"}, int'(ffa), 0);
        check({tag, "_phase"}, int'(phase), 0);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_data_in"}, int'(data_in), 0);
    endtask

    task automatic run_reset();
        @(negedge clk);
        start = 1'b1;
        res_q.push_back(model(pcyc + 193));
        push_ops();
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_rst_phase", int'(phase), 1);
        check("pre_rst_write", int'(write), 1);
        #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        op_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_big();
        int k;
        int e;
        e = 0;
        for (int ph = 0; ph < 2; ph++)
            for (int a = 0; a < N2; a++)
                if (((ph == 1) ? a : 0) != N2 - 1) e++;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("big_done_within_bound", int'(done2), 1);
        check("big_err_saturated", int'(err_count2), (e > 255) ? 255 : e);
        check("big_pass", int'(pass2), 0);
        check("big_first_fail_addr", int'(ffa2), 0);
        check("big_busy", int'(busy2), 0);
    endtask

    initial begin
        clear_faults();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_one(1'b0);
        or_mask = 8'h01;
        run_one(1'b0);
        clear_faults();
        run_one(1'b1);
        prot_en = 1'b1; prot_addr = 13;
        run_one(1'b0);
        clear_faults(); ff_mode = 1'b1;
        run_one(1'b0);
        clear_faults();
        run_reset();
        run_one(1'b0);
        for (int i = 0; i < 6; i++) begin
            random_faults();
            run_one(1'($urandom_range(0, 1)));
        end
        clear_faults();
        run_big();

        check("ops_left", op_q.size(), 0);
        check("results_left", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
